oc8051_icache_fill_ctrl: RTL
============================

// Module: oc8051_icache_fill_ctrl
// PURPOSE
//  Lookup/line-fill controller for the oc8051 instruction cache: owns oc8051_cache_ram (32-bit words, 2^ADR_WIDTH deep).
//  Holds the tag/valid array, serves CPU fetches on RAM port 0 and, on a miss, bursts one line over Wishbone
//  into RAM port 1. Sits inside oc8051_icache between the fetch unit and the external code-memory bus.
// PARAMETERS
//  ADR_WIDTH  7  cache RAM word-address width; must match oc8051_cache_ram
//  LINE_BITS  2  log2(words per line); 4 words/line; LINE_BITS < ADR_WIDTH
//  (derived) TAG_W = 14-ADR_WIDTH, LINES = 2^(ADR_WIDTH-LINE_BITS)
// PORTS
//  clk         in   1          clock, rising edge
//  rst         in   1          asynchronous reset, active-low
//  cpu_adr_i   in   16         code byte address; word = [15:2], idx = [ADR_WIDTH+1:2], tag = [15:ADR_WIDTH+2]
//  cpu_stb_i   in   1          fetch request; adr held stable until cpu_ack_o
//  cpu_dat_o   out  32         fetched word, valid only while cpu_ack_o=1
//  cpu_ack_o   out  1          one-cycle completion pulse
//  inv_i       in   1          invalidate all lines (pulse)
//  busy_o      out  1          1 while in FILL or RESP
//  ram_addr0_o out  ADR_WIDTH  RAM port 0 address
//  ram_data0_i in   32         RAM port 0 data (registered in RAM, 1-cycle latency)
//  ram_addr1_o out  ADR_WIDTH  RAM port 1 address
//  ram_data1_o out  32         RAM port 1 write data
//  ram_wr1_o   out  1          RAM port 1 write strobe
//  wbm_adr_o   out  16         Wishbone byte address, bits [1:0]=0
//  wbm_cyc_o   out  1          Wishbone cycle
//  wbm_stb_o   out  1          Wishbone strobe (equal to cyc)
//  wbm_dat_i   in   32         Wishbone read data
//  wbm_ack_i   in   1          Wishbone ack; ignored outside FILL
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, all valid bits 0, word count 0, inv_pend 0; every registered output 0.
//  States: IDLE, LOOKUP, FILL, RESP.
//  IDLE: ram_addr0_o = cpu_adr_i idx (comb). cpu_stb_i=1 & inv_i=0 -> latch adr, go LOOKUP.
//    inv_i=1 -> clear all valid bits this edge, stay IDLE (a coincident stb is serviced next cycle).
//  LOOKUP: ram_addr0_o = latched idx. hit = valid[line] & tag[line]==latched tag.
//    hit -> cpu_ack_o=1, cpu_dat_o=ram_data0_i, go IDLE. Hit latency: ack 1 cycle after stb sampled.
//    miss -> cnt<=0, go FILL.
//  FILL: wbm_cyc_o=wbm_stb_o=1, wbm_adr_o = {tag, line, cnt, 2'b00} (line-aligned, incrementing order).
//    Each wbm_ack_i: ram_wr1_o=1 (comb), ram_addr1_o={line,cnt}, ram_data1_o=wbm_dat_i; cnt++;
//    if cnt == requested word offset, capture wbm_dat_i into crit register.
//    On ack with cnt=LINES_WORDS-1: valid[line]<=1, tag[line]<=tag, cyc/stb drop next edge, go RESP.
//    Wait states (ack=0) hold address and cnt; no timeout.
//  RESP: cpu_ack_o=1, cpu_dat_o=crit, go IDLE. Miss latency = 1 + N ack cycles + 1.
//  inv_i outside IDLE: sets inv_pend; fill completes normally; on entering IDLE all valid bits clear
//    (including the just-filled line) before any new stb is accepted.
//  ram_wr1_o is never 1 outside FILL; port-0 same-address forwarding is the RAM's job.
//  Reset mid-FILL: cyc/stb drop immediately, no further RAM writes, line stays invalid.
//  cpu_stb_i dropped before ack is a protocol violation; behaviour undefined.
// STRUCTURE
//  oc8051_defines.v: state encodings (IC_IDLE..IC_RESP), LINE_BITS default.
//  Sub-module oc8051_icache_tag: LINES x (TAG_W+1) register array; read by index, write on fill,
//    clear-all on invalidate. Controller FSM, counter and Wishbone drive stay in this module.
// TESTING
//  Cold miss: stb adr 16'h0104 -> wbm_adr 0100,0104,0108,010C; 4 wr1 at ram addr 40..43; ack with word 1 data.
//  Hit: after above, stb 16'h010C -> cpu_ack 1 cycle later, data = 4th burst word, wbm_cyc_o stays 0.
//  Conflict: fill 16'h0104, then stb 16'h0304 (same idx, tag differs) -> miss, refill, old tag evicted.
//  Wait states: wbm_ack every 3rd cycle -> cnt/adr held, still 4 writes, ack after last beat + 1.
//  Invalidate during FILL -> fill completes, cpu_ack given, next stb same adr -> miss (refill).
//  rst=0 mid-FILL after 2 acks -> cyc drops at once; after release stb same adr -> full 4-beat refill.

Source files
------------

// File: rtl/oc8051_icache_fill_ctrl_pkg.sv
// Shared types and defaults for the oc8051 instruction-cache lookup/line-fill controller.
package oc8051_icache_fill_ctrl_pkg;

  localparam int unsigned DefAdrWidth = 7;
  localparam int unsigned DefLineBits = 2;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLookup = 2'd1,
    StFill   = 2'd2,
    StResp   = 2'd3
  } state_e;

endpackage

// File: rtl/oc8051_icache_fill_ctrl_if.sv
// Fetch, cache-RAM and Wishbone signals of the icache fill controller.
interface oc8051_icache_fill_ctrl_if
  import oc8051_icache_fill_ctrl_pkg::*;
#(
  parameter int unsigned ADR_WIDTH = DefAdrWidth
);
  logic [15:0]          cpu_adr_i;
  logic                 cpu_stb_i;
  logic [31:0]          cpu_dat_o;
  logic                 cpu_ack_o;
  logic                 inv_i;
  logic                 busy_o;
  logic [ADR_WIDTH-1:0] ram_addr0_o;
  logic [31:0]          ram_data0_i;
  logic [ADR_WIDTH-1:0] ram_addr1_o;
  logic [31:0]          ram_data1_o;
  logic                 ram_wr1_o;
  logic [15:0]          wbm_adr_o;
  logic                 wbm_cyc_o;
  logic                 wbm_stb_o;
  logic [31:0]          wbm_dat_i;
  logic                 wbm_ack_i;

  modport master (
    input  cpu_adr_i, cpu_stb_i, inv_i, ram_data0_i, wbm_dat_i, wbm_ack_i,
    output cpu_dat_o, cpu_ack_o, busy_o, ram_addr0_o, ram_addr1_o, ram_data1_o, ram_wr1_o,
           wbm_adr_o, wbm_cyc_o, wbm_stb_o
  );

  modport slave (
    output cpu_adr_i, cpu_stb_i, inv_i, ram_data0_i, wbm_dat_i, wbm_ack_i,
    input  cpu_dat_o, cpu_ack_o, busy_o, ram_addr0_o, ram_addr1_o, ram_data1_o, ram_wr1_o,
           wbm_adr_o, wbm_cyc_o, wbm_stb_o
  );

endinterface

// File: rtl/oc8051_icache_fill_ctrl_tag.sv
// Tag/valid array: one entry per cache line, combinational read, write on fill, clear-all.
module oc8051_icache_fill_ctrl_tag
  import oc8051_icache_fill_ctrl_pkg::*;
#(
  parameter int unsigned TAG_W  = 14 - DefAdrWidth,
  parameter int unsigned LINE_W = DefAdrWidth - DefLineBits
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LINE_W-1:0] line,
  input  logic              wr_en,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic              clr,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag
);
  localparam int unsigned Lines = 2 ** LINE_W;

  logic [Lines-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [Lines];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (clr) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[line] <= 1'b1;
    end
  end

  // Tags need no reset: an entry is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[line] <= wr_tag;
    end
  end

  assign rd_valid = valid_q[line];
  assign rd_tag   = tag_q[line];

endmodule

// File: rtl/oc8051_icache_fill_ctrl.sv
// Icache lookup/line-fill controller: serves hits from RAM port 0, fills misses over Wishbone.
module oc8051_icache_fill_ctrl
  import oc8051_icache_fill_ctrl_pkg::*;
#(
  parameter int unsigned ADR_WIDTH = DefAdrWidth,
  parameter int unsigned LINE_BITS = DefLineBits
) (
  input logic                       clk,
  input logic                       rst,
  oc8051_icache_fill_ctrl_if.master bus
);
  localparam int unsigned TagW  = 14 - ADR_WIDTH;
  localparam int unsigned LineW = ADR_WIDTH - LINE_BITS;

  state_e               state_q;
  logic [TagW-1:0]      tag_q;
  logic [LineW-1:0]     line_q;
  logic [LINE_BITS-1:0] off_q;
  logic [LINE_BITS-1:0] cnt_q;
  logic [31:0]          crit_q;
  logic                 inv_pend_q;

  logic            in_idle, in_lookup, in_fill, in_resp;
  logic            hit, beat, last_beat, clr_all;
  logic            rd_valid;
  logic [TagW-1:0] rd_tag;
  logic            unused_adr_lsb;

  assign in_idle   = (state_q == StIdle);
  assign in_lookup = (state_q == StLookup);
  assign in_fill   = (state_q == StFill);
  assign in_resp   = (state_q == StResp);

  assign hit       = rd_valid && (rd_tag == tag_q);
  assign beat      = in_fill && bus.wbm_ack_i;
  assign last_beat = beat && (&cnt_q);
  // A pending invalidate is honoured in IDLE before any new fetch is accepted.
  assign clr_all   = in_idle && (bus.inv_i || inv_pend_q);

  oc8051_icache_fill_ctrl_tag #(
    .TAG_W  (TagW),
    .LINE_W (LineW)
  ) u_tag (
    .clk      (clk),
    .rst      (rst),
    .line     (line_q),
    .wr_en    (last_beat),
    .wr_tag   (tag_q),
    .clr      (clr_all),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      tag_q      <= '0;
      line_q     <= '0;
      off_q      <= '0;
      cnt_q      <= '0;
      crit_q     <= '0;
      inv_pend_q <= 1'b0;
    end else begin
      if (bus.inv_i && !in_idle) begin
        inv_pend_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (clr_all) begin
            inv_pend_q <= 1'b0;
          end else if (bus.cpu_stb_i) begin
            tag_q   <= bus.cpu_adr_i[15:ADR_WIDTH+2];
            line_q  <= bus.cpu_adr_i[ADR_WIDTH+1:LINE_BITS+2];
            off_q   <= bus.cpu_adr_i[LINE_BITS+1:2];
            state_q <= StLookup;
          end
        end
        StLookup: begin
          if (hit) begin
            state_q <= StIdle;
          end else begin
            cnt_q   <= '0;
            state_q <= StFill;
          end
        end
        StFill: begin
          if (beat) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == off_q) begin
              crit_q <= bus.wbm_dat_i;
            end
            if (last_beat) begin
              state_q <= StResp;
            end
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.ram_addr0_o = in_idle ? bus.cpu_adr_i[ADR_WIDTH+1:2] : {line_q, off_q};
  assign bus.cpu_ack_o   = (in_lookup && hit) || in_resp;
  assign bus.cpu_dat_o   = in_resp ? crit_q : bus.ram_data0_i;
  assign bus.busy_o      = in_fill || in_resp;

  assign bus.ram_addr1_o = {line_q, cnt_q};
  assign bus.ram_data1_o = bus.wbm_dat_i;
  assign bus.ram_wr1_o   = beat;

  assign bus.wbm_adr_o   = {tag_q, line_q, cnt_q, 2'b00};
  assign bus.wbm_cyc_o   = in_fill;
  assign bus.wbm_stb_o   = in_fill;

  assign unused_adr_lsb  = ^bus.cpu_adr_i[1:0];

endmodule
